// File: rtl/mt_stream_pkg.sv
// Shared definitions for the MT-side tagged memory stream (mux and unpacker).
package mt_stream_pkg;

    localparam int unsigned TAG_W    = 5;
    localparam int unsigned DATA_W   = 40;
    localparam int unsigned BX_W     = 3;
    localparam int unsigned NPORT_MT = 12;

    localparam logic [TAG_W-1:0] TAG_IDLE = '0;
    localparam logic [TAG_W-1:0] TAG_HDR  = '1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] payload;
    } stream_word_t;

    typedef enum logic [0:0] {
        StWaitHdr,
        StRun
    } unpack_state_e;

    // Tags 1..NPORT_MT address a destination memory.
    function automatic logic tag_is_data(logic [TAG_W-1:0] tag);
        return (tag != TAG_IDLE) && (32'(tag) <= NPORT_MT);
    endfunction

    // Anything that is not idle, header or data is a protocol error.
    function automatic logic tag_is_illegal(logic [TAG_W-1:0] tag);
        return (tag != TAG_IDLE) && (tag != TAG_HDR) && !tag_is_data(tag);
    endfunction

endpackage

// File: rtl/mem_stream_unpack_mt_if.sv
// Bus bundle between the stream source and the unpacker: tagged word in,
// memory write port, event bookkeeping and error flags out.
interface mem_stream_unpack_mt_if
    import mt_stream_pkg::*;
#(
    parameter int unsigned NPORT = NPORT_MT,
    parameter int unsigned CNT_W = 6
);

    stream_word_t              stream_in;
    logic [NPORT-1:0]          wr_en;
    logic [DATA_W-1:0]         wr_data;
    logic [BX_W+CNT_W-1:0]     wr_addr;
    logic [BX_W-1:0]           bx_cur;
    logic                      evt_done;
    logic [NPORT*CNT_W-1:0]    evt_counts;
    logic                      err_tag;
    logic                      err_nohdr;
    logic                      err_bx;
    logic [NPORT-1:0]          ovf;

    // Stream source side.
    modport master (
        output stream_in,
        input  wr_en, wr_data, wr_addr, bx_cur, evt_done, evt_counts,
        input  err_tag, err_nohdr, err_bx, ovf
    );

    // Unpacker side.
    modport slave (
        input  stream_in,
        output wr_en, wr_data, wr_addr, bx_cur, evt_done, evt_counts,
        output err_tag, err_nohdr, err_bx, ovf
    );

endinterface

// File: rtl/mt_port_counter.sv
// Per-port entry counter: saturates at all-ones, flags a sticky overflow when
// a write is requested while saturated, cleared together with the overflow.
module mt_port_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat,
    output logic             ovf
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    assign sat = (cnt_q == '1);
    assign cnt = cnt_q;
    assign ovf = ovf_q;

    // Next count: clear wins, saturated increment turns into overflow.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (sat) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and overflow registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: rtl/mem_stream_unpack_mt.sv
// Receive end of the tagged MT memory stream. Stage 1 registers the incoming
// word, stage 2 decodes it into memory write strobes, BX-paged addresses,
// per-event entry counts and protocol error pulses.
module mem_stream_unpack_mt
    import mt_stream_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input logic                   clk,
    input logic                   reset_n,
    mem_stream_unpack_mt_if.slave bus
);

    localparam int unsigned NPORT = NPORT_MT;

    stream_word_t word_q;

    unpack_state_e state_q, state_d;

    logic [NPORT-1:0]       wr_en_q, wr_en_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;
    logic [BX_W+CNT_W-1:0]  wr_addr_q, wr_addr_d;
    logic [BX_W-1:0]        bx_q, bx_d;
    logic                   evt_done_q, evt_done_d;
    logic [NPORT*CNT_W-1:0] evt_counts_q, evt_counts_d;
    logic                   err_tag_q, err_tag_d;
    logic                   err_nohdr_q, err_nohdr_d;
    logic                   err_bx_q, err_bx_d;

    logic                   cnt_clr;
    logic [NPORT-1:0]       cnt_inc;
    logic [CNT_W-1:0]       cnt [NPORT];
    logic [NPORT-1:0]       cnt_sat;
    logic [NPORT-1:0]       ovf;

    logic                   is_hdr;
    logic                   is_data;
    logic                   is_illegal;
    logic [BX_W-1:0]        hdr_bx;
    logic [BX_W-1:0]        bx_inc;

    // Stage 1: capture the raw stream word; reset leaves an idle word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
        end else begin
            word_q <= bus.stream_in;
        end
    end

    assign is_hdr     = (word_q.tag == TAG_HDR);
    assign is_data    = tag_is_data(word_q.tag);
    assign is_illegal = tag_is_illegal(word_q.tag);
    assign hdr_bx     = word_q.payload[DATA_W-1 -: BX_W];
    assign bx_inc     = bx_q + BX_W'(1);

    for (genvar p = 0; p < NPORT; p++) begin : g_cnt
        mt_port_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (cnt_clr),
            .inc     (cnt_inc[p]),
            .cnt     (cnt[p]),
            .sat     (cnt_sat[p]),
            .ovf     (ovf[p])
        );
    end

    // Decode the stage-1 word: FSM next state, counter control, stage-2 outputs.
    always_comb begin
        state_d      = state_q;
        wr_en_d      = '0;
        wr_data_d    = '0;
        wr_addr_d    = '0;
        bx_d         = bx_q;
        evt_done_d   = 1'b0;
        evt_counts_d = evt_counts_q;
        err_tag_d    = 1'b0;
        err_nohdr_d  = 1'b0;
        err_bx_d     = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = '0;

        unique case (state_q)
            StWaitHdr: begin
                // First header after reset opens an event without closing one.
                if (is_hdr) begin
                    bx_d    = hdr_bx;
                    cnt_clr = 1'b1;
                    state_d = StRun;
                end else if (is_data) begin
                    err_nohdr_d = 1'b1;
                end else if (is_illegal) begin
                    err_tag_d = 1'b1;
                end
            end
            StRun: begin
                if (is_hdr) begin
                    for (int p = 0; p < NPORT; p++) begin
                        evt_counts_d[p*CNT_W +: CNT_W] = cnt[p];
                    end
                    evt_done_d = 1'b1;
                    err_bx_d   = (hdr_bx != bx_inc);
                    bx_d       = hdr_bx;
                    cnt_clr    = 1'b1;
                end else if (is_data) begin
                    for (int p = 0; p < NPORT; p++) begin
                        if (word_q.tag == TAG_W'(p + 1)) begin
                            // Counter raises ovf itself when already saturated.
                            cnt_inc[p] = 1'b1;
                            if (!cnt_sat[p]) begin
                                wr_en_d[p] = 1'b1;
                                wr_data_d  = word_q.payload;
                                wr_addr_d  = {bx_q, cnt[p]};
                            end
                        end
                    end
                end else if (is_illegal) begin
                    err_tag_d = 1'b1;
                end
            end
            default: state_d = StWaitHdr;
        endcase
    end

    // Stage 2: FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StWaitHdr;
            wr_en_q      <= '0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            bx_q         <= '0;
            evt_done_q   <= 1'b0;
            evt_counts_q <= '0;
            err_tag_q    <= 1'b0;
            err_nohdr_q  <= 1'b0;
            err_bx_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            wr_addr_q    <= wr_addr_d;
            bx_q         <= bx_d;
            evt_done_q   <= evt_done_d;
            evt_counts_q <= evt_counts_d;
            err_tag_q    <= err_tag_d;
            err_nohdr_q  <= err_nohdr_d;
            err_bx_q     <= err_bx_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.bx_cur     = bx_q;
    assign bus.evt_done   = evt_done_q;
    assign bus.evt_counts = evt_counts_q;
    assign bus.err_tag    = err_tag_q;
    assign bus.err_nohdr  = err_nohdr_q;
    assign bus.err_bx     = err_bx_q;
    assign bus.ovf        = ovf;

endmodule
